// File: rtl/sif_capture_fifo_if.sv
// simple_if: byte bus with a valid strobe and no backpressure.
interface simple_if;
    logic [7:0] data;
    logic       valid;
    modport master (output data, valid);
    modport slave  (input data, valid);
endinterface

// File: rtl/sif_capture_fifo.sv
// sif_capture_fifo: captures simple_if bytes into a FWFT FIFO presented as a valid/ready stream.
// SIF_CAPTURE_STATS_EN adds push_cnt, a wrapping count of accepted pushes.
module sif_capture_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    simple_if.slave       intf,
    input  logic          out_ready,
    output logic [7:0]    out_data,
    output logic          out_valid,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
`ifdef SIF_CAPTURE_STATS_EN
    output logic [15:0]   push_cnt,
`endif
    output logic [7:0]    ovf_cnt
);
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          push_req, pop, push_acc, drop;

    // X or Z on valid must not count as a push
    assign push_req  = intf.valid === 1'b1;
    assign empty     = level == '0;
    assign full      = level == (AW+1)'(DEPTH);
    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    assign push_acc  = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;

    always_ff @(posedge clk)
        if (push_acc) mem[wr_ptr] <= intf.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf_cnt <= '0;
        end else begin
            if (push_acc) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push_acc) - (AW+1)'(pop);
            if (drop && ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 8'd1;
        end
    end

`ifdef SIF_CAPTURE_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) push_cnt <= '0;
        else if (push_acc) push_cnt <= push_cnt + 16'd1;
    end
`endif
endmodule

// File: tb/tb_sif_capture_fifo.sv
// tb_sif_capture_fifo: scoreboard bench; bytes are queued on accepted push and compared on pop.
module tb_sif_capture_fifo;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_valid, full, empty;
    logic [2:0]  level;
    logic [7:0]  ovf_cnt;
`ifdef SIF_CAPTURE_STATS_EN
    logic [15:0] push_cnt;
`endif
    int          checks = 0;
    int          errors = 0;
    int          m_lvl = 0;
    int          m_ovf = 0;
    int          m_pc = 0;
    logic [7:0]  exp_q [$];

    simple_if intf ();

    sif_capture_fifo #(.DEPTH(4), .AW(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .intf      (intf),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .full      (full),
        .empty     (empty),
        .level     (level),
`ifdef SIF_CAPTURE_STATS_EN
        .push_cnt  (push_cnt),
`endif
        .ovf_cnt   (ovf_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // inputs change only at posedge+1, so a handshake seen here pops at the next posedge
    always @(negedge clk) begin
        if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) check("pop_unexpected", 32'(out_data), 32'hFFFF_FFFF);
            else check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    task automatic cycle(input logic v, input logic [7:0] d, input logic r);
        logic pop, acc;
        intf.valid = v;
        intf.data  = d;
        out_ready  = r;
        pop = m_lvl > 0 && r;
        acc = (v === 1'b1) && (m_lvl < 4 || pop);
        if (acc) begin
            exp_q.push_back(d);
            m_pc++;
        end else if (v === 1'b1 && m_ovf != 255) m_ovf++;
        m_lvl = m_lvl + int'(acc) - int'(pop);
        @(posedge clk);
        #1;
        check("level", 32'(level), 32'(m_lvl));
        check("full", 32'(full), 32'(m_lvl == 4));
        check("empty", 32'(empty), 32'(m_lvl == 0));
        check("out_valid", 32'(out_valid), 32'(m_lvl != 0));
        check("ovf_cnt", 32'(ovf_cnt), 32'(m_ovf));
`ifdef SIF_CAPTURE_STATS_EN
        check("push_cnt", 32'(push_cnt), 32'(m_pc & 32'hFFFF));
`endif
    endtask

    task automatic drain();
        for (int i = 0; i < 8 && m_lvl > 0; i++) cycle(1'b0, 8'h00, 1'b1);
        check("drained", 32'(m_lvl), 32'd0);
    endtask

    task automatic fill(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, base + 8'(i), 1'b0);
    endtask

    initial begin
        logic [7:0] fill_bytes [6];
        fill_bytes = '{8'hAB, 8'hCD, 8'hEF, 8'h12, 8'h34, 8'h56};
        rst_n = 1'b0;
        intf.valid = 1'b0;
        intf.data = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_level", 32'(level), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        rst_n = 1'b1;
        // single byte, held then popped
        cycle(1'b1, 8'hAB, 1'b0);
        check("single_data", 32'(out_data), 32'hAB);
        cycle(1'b0, 8'h00, 1'b0);
        check("single_hold", 32'(out_data), 32'hAB);
        cycle(1'b0, 8'h00, 1'b1);
        // empty FIFO with push and ready: stored, not popped this edge
        cycle(1'b1, 8'h5A, 1'b1);
        check("bypass_lvl", 32'(level), 32'd1);
        drain();
        // fill with overflow
        foreach (fill_bytes[i]) cycle(1'b1, fill_bytes[i], 1'b0);
        check("ovf_two", 32'(ovf_cnt), 32'd2);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_head", 32'(out_data), 32'hAB);
        drain();
        // full with simultaneous push and pop
        fill(8'h40, 4);
        cycle(1'b1, 8'h77, 1'b1);
        check("fullpp_lvl", 32'(level), 32'd4);
        check("fullpp_ovf", 32'(ovf_cnt), 32'd2);
        drain();
        // X on valid is not a push
        cycle(1'bx, 8'h99, 1'b0);
        check("x_valid_lvl", 32'(level), 32'd0);
        // async reset with two entries stored
        fill(8'h60, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_empty", 32'(empty), 32'd1);
        check("arst_level", 32'(level), 32'd0);
        check("arst_ovf", 32'(ovf_cnt), 32'd0);
        exp_q.delete();
        m_lvl = 0;
        m_ovf = 0;
        m_pc = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        // streaming across pointer wraps
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 8'(i), 1'b1);
            check("stream_lvl_le1", 32'(level <= 3'd1), 32'd1);
        end
        drain();
        check("stream_ovf", 32'(ovf_cnt), 32'd0);
`ifdef SIF_CAPTURE_STATS_EN
        foreach (fill_bytes[i]) cycle(1'b1, fill_bytes[i], 1'b0);
        check("stats_pc4", 32'(push_cnt), 32'd24);
        drain();
        cycle(1'bx, 8'h11, 1'b0);
        check("stats_x", 32'(push_cnt), 32'd24);
`endif
        repeat (2) cycle(1'b0, 8'h00, 1'b1);
        check("q_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
